// File: rtl/pio_pulse_out_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_pulse_out_if                                                   |
// | Avalon-MM slave bus bundle for the pulse-output PIO (4-word map).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface pio_pulse_out_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface
`default_nettype wire

// File: rtl/pio_pulse_out.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_pulse_out                                                      |
// | Output PIO register with a hardware-timed, exact-length pulse      |
// | engine, sticky done flag and level interrupt.                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pio_pulse_out #(
   parameter int                 WIDTH       = 8,
   parameter int                 CNT_W       = 16,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   pio_pulse_out_if.slave        bus,
   output logic [WIDTH-1:0]      out_port,
   output logic                  irq
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_LEN    = 2'd1;
   localparam logic [1:0] ADDR_PULSE  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [CNT_W-1:0]   len_q,   len_d;
   logic [WIDTH-1:0]   mask_q,  mask_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               done_q,  done_d;
   logic               ien_q,   ien_d;
   logic [WIDTH-1:0]   out_q,   out_d;

   logic               w_wr;
   logic               w_end;
   logic               w_start;
   logic [WIDTH-1:0]   w_wmask;
   logic [31:0]        w_rd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         data_q  <= RESET_VALUE;
         len_q   <= '0;
         mask_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         ien_q   <= 1'b0;
         out_q   <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         len_q   <= len_d;
         mask_q  <= mask_d;
         count_q <= count_d;
         done_q  <= done_d;
         ien_q   <= ien_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      w_wr    = bus.chipselect & ~bus.write_n;
      w_wmask = bus.writedata[WIDTH-1:0];
      w_end   = (state_q == ACTIVE) && (count_q == CNT_W'(1));
      // The final pulse edge frees the engine, so a new request may start there.
      w_start = w_wr && (bus.address == ADDR_PULSE)
                && ((state_q == IDLE) || w_end)
                && (|w_wmask) && (|len_q);

      state_d = state_q;
      data_d  = data_q;
      len_d   = len_q;
      mask_d  = mask_q;
      count_d = count_q;
      done_d  = done_q;
      ien_d   = ien_q;

      if (w_wr) begin
         case (bus.address)
            ADDR_DATA:   data_d = bus.writedata[WIDTH-1:0];
            ADDR_LEN:    len_d  = bus.writedata[CNT_W-1:0];
            ADDR_STATUS: begin
               ien_d = bus.writedata[2];
               if (bus.writedata[1]) begin
                  done_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      case (state_q)
         ACTIVE: begin
            count_d = count_q - CNT_W'(1);
            // Done set is evaluated after the W1C so that the set wins.
            if (w_end) begin
               state_d = IDLE;
               mask_d  = '0;
               done_d  = 1'b1;
            end
         end
         default: ;
      endcase

      if (w_start) begin
         state_d = ACTIVE;
         mask_d  = w_wmask;
         count_d = len_q;
      end

      out_d = data_d ^ mask_d;
   end

   always_comb begin
      w_rd = '0;
      case (bus.address)
         ADDR_DATA:   w_rd[WIDTH-1:0] = data_q;
         ADDR_LEN:    w_rd[CNT_W-1:0] = len_q;
         ADDR_PULSE:  w_rd[WIDTH-1:0] = (state_q == ACTIVE) ? mask_q : '0;
         ADDR_STATUS: w_rd[2:0]       = {ien_q, done_q, (state_q == ACTIVE)};
         default:     w_rd            = '0;
      endcase
   end

   assign bus.readdata = w_rd;
   assign out_port     = out_q;
   assign irq          = done_q & ien_q;

endmodule
`default_nettype wire
